// File: rtl/rvfi_liveness_trigger_if.sv
// RVFI retire-stream bundle observed by the liveness trigger sequencer.
// master drives the retire channels; slave observes them.
interface rvfi_liveness_trigger_if #(
    parameter int unsigned NRET = 1
);
    logic [NRET-1:0]    rvfi_valid;
    logic [NRET-1:0]    rvfi_halt;
    logic [64*NRET-1:0] rvfi_order;

    modport master (output rvfi_valid, rvfi_halt, rvfi_order);
    modport slave  (input  rvfi_valid, rvfi_halt, rvfi_order);
endinterface

// File: rtl/rvfi_liveness_trigger.sv
// Liveness trigger/check sequencer for a riscv-formal testbench.
// Fires trig on the first eligible non-halt retirement on CHANNEL after
// TRIG_MIN warm-up cycles, then check exactly CHECK_DELAY cycles later.
// Reports the captured order, successor retirement and its latency.
// Optional feature macro: RISCV_FORMAL_LIVENESS_STALLCNT_EN (stall_max).
module rvfi_liveness_trigger #(
    parameter int unsigned NRET        = 1,
    parameter int unsigned CHANNEL     = 0,
    parameter int unsigned TRIG_MIN    = 10,
    parameter int unsigned CHECK_DELAY = 20,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    rvfi_liveness_trigger_if.slave rvfi,
    output logic                   trig,
    output logic                   check,
    output logic [63:0]            trig_order,
    output logic                   next_seen,
    output logic [CNT_W-1:0]       next_lat,
    output logic                   done,
    output logic [CNT_W-1:0]       stall_max
);
    localparam int unsigned      ORDER_W   = 64;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((TRIG_MIN == 0) ? 32'd0 : TRIG_MIN - 1);
    localparam logic [CNT_W-1:0] DLY_INIT  = CNT_W'(CHECK_DELAY - 1);

    typedef enum logic [2:0] {
        S_WARM = 3'd0,
        S_SEEK = 3'd1,
        S_WAIT = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // With no warm-up requirement the sequencer may trigger in cycle 0.
    localparam state_t RESET_STATE = (TRIG_MIN == 0) ? S_SEEK : S_WARM;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cyc;
    logic [CNT_W-1:0]   dly;
    logic [CNT_W-1:0]   lat;
    logic [CNT_W-1:0]   lat_inc;
    logic [ORDER_W-1:0] ch_order;
    logic [ORDER_W-1:0] succ_ref;
    logic               trig_raw;
    logic               succ_active;
    logic               succ_hit;

    assign ch_order    = rvfi.rvfi_order[ORDER_W*CHANNEL +: ORDER_W];
    assign trig_raw    = (state == S_SEEK) & rvfi.rvfi_valid[CHANNEL] & ~rvfi.rvfi_halt[CHANNEL];
    assign lat_inc     = (lat == CNT_MAX) ? lat : lat + CNT_W'(1);
    assign succ_active = trig_raw | (state == S_WAIT) | (state == S_CHK);
    // In the trig cycle trig_order is not yet registered, so use the live order.
    assign succ_ref    = (state == S_SEEK) ? ch_order + 64'd1 : trig_order + 64'd1;

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) state <= RESET_STATE;
        else         state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_WARM:  if (cyc == WARM_LAST) state_n = S_SEEK;
            S_SEEK:  if (trig_raw) state_n = (CHECK_DELAY == 1) ? S_CHK : S_WAIT;
            S_WAIT:  if (dly == CNT_W'(1)) state_n = S_CHK;
            S_CHK:   state_n = S_DONE;
            S_DONE:  state_n = S_DONE;
            default: state_n = RESET_STATE;
        endcase
    end

    // Combinational strobes, silenced while reset is asserted.
    always_comb begin
        trig  = 1'b0;
        check = 1'b0;
        if (resetn) begin
            trig  = trig_raw;
            check = (state == S_CHK);
        end
    end

    // Any channel retiring the successor of the captured order.
    always_comb begin
        succ_hit = 1'b0;
        for (int unsigned i = 0; i < NRET; i++) begin
            if (rvfi.rvfi_valid[i] && (rvfi.rvfi_order[ORDER_W*i +: ORDER_W] == succ_ref))
                succ_hit = 1'b1;
        end
    end

    // Warm-up, delay and latency counters plus captured results.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cyc        <= '0;
            dly        <= '0;
            lat        <= '0;
            trig_order <= '0;
            next_seen  <= 1'b0;
            next_lat   <= '0;
            done       <= 1'b0;
        end else begin
            if (state == S_WARM && cyc != CNT_MAX)
                cyc <= cyc + CNT_W'(1);

            if (trig_raw) begin
                trig_order <= ch_order;
                dly        <= DLY_INIT;
                lat        <= '0;
            end else if (state == S_WAIT) begin
                if (dly != '0) dly <= dly - CNT_W'(1);
                lat <= lat_inc;
            end else if (state == S_CHK) begin
                lat <= lat_inc;
            end

            if (succ_active && succ_hit && !next_seen) begin
                next_seen <= 1'b1;
                next_lat  <= trig_raw ? '0 : lat_inc;
            end

            done <= (state_n == S_DONE);
        end
    end

`ifdef RISCV_FORMAL_LIVENESS_STALLCNT_EN
    logic             in_win;
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_n;

    assign in_win = (state == S_WAIT) | (state == S_CHK);

    // Length of the current no-retirement run inside the trig..check window.
    always_comb begin
        run_n = '0;
        if (in_win && !(|rvfi.rvfi_valid))
            run_n = (run == CNT_MAX) ? run : run + CNT_W'(1);
    end

    // Track the longest run; frozen once the window has closed.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            run       <= '0;
            stall_max <= '0;
        end else begin
            run <= run_n;
            if (in_win && run_n > stall_max)
                stall_max <= run_n;
        end
    end
`else
    assign stall_max = '0;
`endif

endmodule

// File: tb/tb_rvfi_liveness_trigger.sv
// Self-checking bench for rvfi_liveness_trigger: a directed vector table,
// hand-written corner sequences and a random phase, all cross-checked by a
// cycle-indexed reference model for three parameterisations.
module tb_rvfi_liveness_trigger;
    localparam int NDUT  = 3;
    localparam int CNT_W = 16;
`ifdef RISCV_FORMAL_LIVENESS_STALLCNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clock;
    logic resetn;

    rvfi_liveness_trigger_if #(.NRET(2)) ifc ();

    logic [NDUT-1:0]  trig_v, check_v, seen_v, done_v;
    logic [63:0]      tord_v  [NDUT];
    logic [CNT_W-1:0] nlat_v  [NDUT];
    logic [CNT_W-1:0] stall_v [NDUT];

    // DUT 0: channel 0, warm-up 3, delay 4.
    rvfi_liveness_trigger #(.NRET(2), .CHANNEL(0), .TRIG_MIN(3), .CHECK_DELAY(4), .CNT_W(CNT_W)) u_a (
        .clock(clock), .resetn(resetn), .rvfi(ifc),
        .trig(trig_v[0]), .check(check_v[0]), .trig_order(tord_v[0]), .next_seen(seen_v[0]),
        .next_lat(nlat_v[0]), .done(done_v[0]), .stall_max(stall_v[0]));
    // DUT 1: channel 1, no warm-up, delay 10.
    rvfi_liveness_trigger #(.NRET(2), .CHANNEL(1), .TRIG_MIN(0), .CHECK_DELAY(10), .CNT_W(CNT_W)) u_b (
        .clock(clock), .resetn(resetn), .rvfi(ifc),
        .trig(trig_v[1]), .check(check_v[1]), .trig_order(tord_v[1]), .next_seen(seen_v[1]),
        .next_lat(nlat_v[1]), .done(done_v[1]), .stall_max(stall_v[1]));
    // DUT 2: channel 1, warm-up 1, minimum delay 1.
    rvfi_liveness_trigger #(.NRET(2), .CHANNEL(1), .TRIG_MIN(1), .CHECK_DELAY(1), .CNT_W(CNT_W)) u_c (
        .clock(clock), .resetn(resetn), .rvfi(ifc),
        .trig(trig_v[2]), .check(check_v[2]), .trig_order(tord_v[2]), .next_seen(seen_v[2]),
        .next_lat(nlat_v[2]), .done(done_v[2]), .stall_max(stall_v[2]));

    function automatic int p_ch(input int k);   return (k == 0) ? 0 : 1; endfunction
    function automatic int p_tmin(input int k); return (k == 0) ? 3 : ((k == 1) ? 0 : 1); endfunction
    function automatic int p_cd(input int k);   return (k == 0) ? 4 : ((k == 1) ? 10 : 1); endfunction

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: cycle since reset release, trig cycle, successor cycle.
    int          m_c    [NDUT];
    int          m_t    [NDUT];
    int          m_s    [NDUT];
    int          m_nlat [NDUT];
    int          m_run  [NDUT];
    int          m_max  [NDUT];
    logic [63:0] m_tord [NDUT];
    bit          m_known = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", nm, k, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_c[k] = 0; m_t[k] = -1; m_s[k] = -1; m_nlat[k] = 0;
        m_run[k] = 0; m_max[k] = 0; m_tord[k] = '0;
    endtask

    // Compare every DUT against the model for the current cycle, then advance it.
    task automatic model_cycle();
        for (int k = 0; k < NDUT; k++) begin
            int          ch;
            logic [63:0] co;
            logic        et, ec, anyv, hit;
            ch   = p_ch(k);
            co   = ifc.rvfi_order[64*ch +: 64];
            anyv = |ifc.rvfi_valid;
            et   = resetn && (m_t[k] < 0) && (m_c[k] >= p_tmin(k)) &&
                   ifc.rvfi_valid[ch] && !ifc.rvfi_halt[ch];
            ec   = resetn && (m_t[k] >= 0) && (m_c[k] == m_t[k] + p_cd(k));
            chk("trig", k, 64'(trig_v[k]), 64'(et));
            chk("check", k, 64'(check_v[k]), 64'(ec));
            if (m_known) begin
                chk("done", k, 64'(done_v[k]), 64'((m_t[k] >= 0) && (m_c[k] >= m_t[k] + p_cd(k) + 1)));
                chk("trig_order", k, tord_v[k], m_tord[k]);
                chk("next_seen", k, 64'(seen_v[k]), 64'(m_s[k] >= 0));
                chk("next_lat", k, 64'(nlat_v[k]), 64'(m_nlat[k]));
                chk("stall_max", k, 64'(stall_v[k]), STALL_EN ? 64'(m_max[k]) : 64'd0);
            end
            if (!resetn) begin
                model_reset(k);
            end else begin
                if (et) begin
                    m_t[k]    = m_c[k];
                    m_tord[k] = co;
                end
                if (m_t[k] >= 0 && m_c[k] <= m_t[k] + p_cd(k) && m_s[k] < 0) begin
                    hit = 1'b0;
                    for (int i = 0; i < 2; i++)
                        if (ifc.rvfi_valid[i] && ifc.rvfi_order[64*i +: 64] == m_tord[k] + 64'd1)
                            hit = 1'b1;
                    if (hit) begin
                        m_s[k]    = m_c[k];
                        m_nlat[k] = m_c[k] - m_t[k];
                    end
                end
                if (m_t[k] >= 0 && m_c[k] >= m_t[k] + 1 && m_c[k] <= m_t[k] + p_cd(k)) begin
                    m_run[k] = anyv ? 0 : m_run[k] + 1;
                    if (m_run[k] > m_max[k]) m_max[k] = m_run[k];
                end
                m_c[k]++;
            end
        end
        m_known = 1'b1;
    endtask

    // One clock cycle: drive after the falling edge, sample 1 time unit later.
    task automatic step(input logic rn, input logic [1:0] v, input logic [1:0] h,
                        input logic [63:0] o0, input logic [63:0] o1);
        @(negedge clock);
        resetn         = rn;
        ifc.rvfi_valid = v;
        ifc.rvfi_halt  = h;
        ifc.rvfi_order = {o1, o0};
        #1;
        model_cycle();
    endtask

    task automatic idle();
        step(1'b1, 2'b00, 2'b00, 64'd0, 64'd0);
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 2'b00, 64'd0, 64'd0);
    endtask

    typedef struct {
        logic        rn;
        logic [1:0]  valid;
        logic [1:0]  halt;
        logic [63:0] o0;
        logic        e_trig;
        logic        e_check;
        logic        e_done;
        logic        e_seen;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [63:0] base;
        logic [1:0]  rv, rh;

        // Channel 0 retires every cycle with order == cycle number.
        tbl[0] = '{1'b0, 2'b00, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 10; c++)
            tbl[c+1] = '{1'b1, 2'b01, 2'b00, 64'(c), (c == 3), (c == 7), (c >= 8), (c >= 5)};

        resetn         = 1'b0;
        ifc.rvfi_valid = '0;
        ifc.rvfi_halt  = '0;
        ifc.rvfi_order = '0;
        for (int k = 0; k < NDUT; k++) model_reset(k);
        do_reset();
        do_reset();

        // Basic trig/successor/check/done sequence from the vector table.
        for (int r = 0; r < 11; r++) begin
            step(tbl[r].rn, tbl[r].valid, tbl[r].halt, tbl[r].o0, 64'd0);
            chk("tbl_trig",  r, 64'(trig_v[0]),  64'(tbl[r].e_trig));
            chk("tbl_check", r, 64'(check_v[0]), 64'(tbl[r].e_check));
            chk("tbl_done",  r, 64'(done_v[0]),  64'(tbl[r].e_done));
            chk("tbl_seen",  r, 64'(seen_v[0]),  64'(tbl[r].e_seen));
        end
        chk("tbl_trig_order", 0, tord_v[0], 64'd3);
        chk("tbl_next_lat", 0, 64'(nlat_v[0]), 64'd1);

        // Halted retirement does not trigger; next valid at cycle 6 with order 10.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 3)       step(1'b1, 2'b01, 2'b00, 64'(c), 64'd0);
            else if (c == 3) step(1'b1, 2'b01, 2'b01, 64'd3, 64'd0);
            else if (c < 6)  idle();
            else             step(1'b1, 2'b01, 2'b00, 64'(c + 4), 64'd0);
            chk("halt_trig", c, 64'(trig_v[0]), 64'(c == 6));
            chk("halt_check", c, 64'(check_v[0]), 64'(c == 10));
        end
        chk("halt_trig_order", 0, tord_v[0], 64'd10);

        // Successor on another channel in the trig cycle itself.
        do_reset();
        idle(); idle(); idle();
        step(1'b1, 2'b11, 2'b00, 64'd5, 64'd6);
        chk("same_cycle_trig", 0, 64'(trig_v[0]), 64'd1);
        idle();
        chk("same_cycle_seen", 0, 64'(seen_v[0]), 64'd1);
        chk("same_cycle_lat", 0, 64'(nlat_v[0]), 64'd0);
        for (int c = 5; c < 9; c++) idle();
        chk("same_cycle_done", 0, 64'(done_v[0]), 64'd1);

        // Order wrap: all-ones followed two cycles later by order 0.
        do_reset();
        idle(); idle(); idle();
        step(1'b1, 2'b01, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        idle();
        step(1'b1, 2'b01, 2'b00, 64'd0, 64'd0);
        idle();
        chk("wrap_seen", 0, 64'(seen_v[0]), 64'd1);
        chk("wrap_lat", 0, 64'(nlat_v[0]), 64'd2);
        idle(); idle();

        // No successor ever retires.
        do_reset();
        idle(); idle(); idle();
        step(1'b1, 2'b01, 2'b00, 64'd100, 64'd0);
        for (int c = 4; c < 8; c++) step(1'b1, 2'b01, 2'b00, 64'(200 + c), 64'd0);
        chk("nosucc_check", 0, 64'(check_v[0]), 64'd1);
        chk("nosucc_seen", 0, 64'(seen_v[0]), 64'd0);

        // Reset pulse in the middle of the wait window.
        do_reset();
        for (int c = 0; c < 5; c++) step(1'b1, 2'b01, 2'b00, 64'(c), 64'd0);
        step(1'b0, 2'b01, 2'b00, 64'd5, 64'd0);
        chk("midrst_check", 0, 64'(check_v[0]), 64'd0);
        step(1'b1, 2'b01, 2'b00, 64'd6, 64'd0);
        chk("midrst_trig", 0, 64'(trig_v[0]), 64'd0);
        chk("midrst_done", 0, 64'(done_v[0]), 64'd0);
        chk("midrst_seen", 0, 64'(seen_v[0]), 64'd0);
        chk("midrst_order", 0, tord_v[0], 64'd0);
        for (int c = 1; c < 9; c++) begin
            step(1'b1, 2'b01, 2'b00, 64'(c + 6), 64'd0);
            chk("midrst_re_trig", c, 64'(trig_v[0]), 64'(c == 3));
            chk("midrst_re_check", c, 64'(check_v[0]), 64'(c == 7));
        end
        chk("midrst_re_done", 0, 64'(done_v[0]), 64'd1);

        // Stall window on the delay-10 instance: no retirement in T+2..T+5.
        do_reset();
        step(1'b1, 2'b10, 2'b00, 64'd0, 64'd0);
        chk("stall_trig", 1, 64'(trig_v[1]), 64'd1);
        step(1'b1, 2'b10, 2'b00, 64'd0, 64'd50);
        for (int c = 2; c < 6; c++) idle();
        for (int c = 6; c < 12; c++) begin
            step(1'b1, 2'b10, 2'b00, 64'd0, 64'(60 + c));
            if (c == 10) chk("stall_check", 1, 64'(check_v[1]), 64'd1);
        end
        chk("stall_max", 1, 64'(stall_v[1]), STALL_EN ? 64'd4 : 64'd0);
        chk("stall_done", 1, 64'(done_v[1]), 64'd1);

        // Random traffic with occasional resets, checked only by the model.
        do_reset();
        base = 64'd1000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) base = 64'hFFFF_FFFF_FFFF_FFFE;
            base = base + 64'($urandom_range(0, 1));
            rv   = 2'($urandom);
            rh   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            step(($urandom_range(0, 39) != 0), rv, rh,
                 base + 64'($urandom_range(0, 2)), base + 64'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
